feature_map_serializer: RTL and testbench
=========================================

Name: feature_map_serializer

Overview:
- Parametrised successor to the conv-stage feature map streamer.
- Accepts one parallel vector of NUM_CHANNELS signed conv outputs per handshake and buffers vectors in a small FIFO.
- Emits the buffered vectors one channel per cycle on a valid/ready stream, tagged with channel index and map-position markers (start-of-frame, end-of-line, end-of-frame).
- Sits between the conv block output and downstream pooling/storage; provides backpressure and a sticky overflow flag.

Parameters:
- FEATURE_WIDTH, 16, bit width of each signed feature.
- NUM_CHANNELS, 6, conv filters per input vector; must be ≥ 2.
- FIFO_DEPTH, 4, number of whole vectors buffered; power of two, ≥ 2.
- MAP_WIDTH, 24, feature-map columns per row.
- MAP_HEIGHT, 24, feature-map rows per frame.

Ports:
- clk, input, 1, clock.
- rst, input, 1, synchronous active-high reset.
- i_features_valid, input, 1, input vector valid.
- o_features_ready, output, 1, FIFO can accept a vector.
- i_features, input, NUM_CHANNELS x FEATURE_WIDTH signed, parallel feature vector.
- o_feature_valid, output, 1, serial output valid.
- i_feature_ready, input, 1, downstream accepts the serial output.
- o_feature, output, FEATURE_WIDTH signed, current channel's feature.
- o_channel, output, $clog2(NUM_CHANNELS), channel index of o_feature.
- o_sof, output, 1, first channel of map position (0,0).
- o_eol, output, 1, last channel of the last column in a row.
- o_eof, output, 1, last channel of the last column in the last row.
- o_overflow, output, 1, sticky: a vector arrived while not ready.

Behaviour:
- Reset: one clock, reset is synchronous and active-high. While rst is high and in the following cycle, the block holds:
  - FIFO empty; rd/wr pointers, channel index, col and row counters = 0.
  - o_feature_valid = 0, o_overflow = 0.
  - o_features_ready = 0 while rst is high.
- Reset asserted mid-operation discards all buffered data and any partially emitted vector; no further outputs are produced from that data.
- Input side:
  - o_features_ready = (count < FIFO_DEPTH) && !rst.
  - A vector is written when i_features_valid && o_features_ready; all channels are captured in one cycle.
  - i_features_valid while o_features_ready = 0 (rst low): the vector is dropped, o_overflow is set to 1 and stays 1 until rst.
- Full plus simultaneous pop: ready is computed from the registered count and does not look ahead, so a write in a cycle where the last channel pops while full is not accepted.
- Output side:
  - o_feature_valid = (count != 0).
  - o_feature = head vector[channel index]; o_channel = channel index.
  - The handshake fires on o_feature_valid && i_feature_ready. On each fire, the channel index increments.
  - On a fire with channel index = NUM_CHANNELS-1: index returns to 0, the head vector is popped, and col/row advance.
  - col wraps MAP_WIDTH-1 → 0 and increments row; row wraps MAP_HEIGHT-1 → 0 (the next frame starts seamlessly).
  - Outputs hold stable while valid && !ready.
- Simultaneous push and pop in one cycle: count is unchanged; both pointers advance modulo FIFO_DEPTH.
- Markers (qualified by o_feature_valid):
  - o_sof = (col==0 && row==0 && channel==0).
  - o_eol = (col==MAP_WIDTH-1 && channel==NUM_CHANNELS-1).
  - o_eof = o_eol && row==MAP_HEIGHT-1.
- Latency: a vector written in cycle N presents channel 0 in cycle N+1 if the FIFO was empty. Steady-state throughput is one channel per cycle, one vector per NUM_CHANNELS cycles.
- Output data is driven from registered FIFO storage; no arithmetic widening; data is bit-exact to the input unless the optional feature is enabled.

Optional Feature:
- Macro FEATURE_SERIALIZER_RELU_EN.
- Defined: o_feature = 0 whenever the selected buffered feature is negative (MSB set); otherwise passed through. Applied combinationally at the output mux; buffer contents and markers are unchanged.
- Undefined: o_feature is the raw signed buffered value.

Test Plan:
- Reset then one vector {1,-2,3,-4,5,-6}, i_feature_ready=1 → outputs 1,-2,3,-4,5,-6 on consecutive cycles starting 1 cycle after write; o_channel 0..5; o_sof=1 on the first word only. With FEATURE_SERIALIZER_RELU_EN: 1,0,3,0,5,0.
- Continuous vector input every 6 cycles, ready=1, for 24x24 positions → 3456 output words, no overflow; o_eol on words 144,288,…; o_eof only on word 3456; the next frame's first word has o_sof=1.
- i_feature_ready=0 with 4 vectors pushed → o_features_ready drops after the 4th. A 5th push sets o_overflow=1, which stays 1. On ready release, exactly the 4 stored vectors are emitted in order.
- Ready toggled 1,0,1,0 randomly mid-vector → o_feature/o_channel stable during stalls; channel sequence is never skipped or repeated.
- Full FIFO with ready=1: push coincident with the last-channel pop → push not accepted (ready=0 that cycle). Push in the following cycle is accepted; count returns to 4.
- rst pulsed for 1 cycle after channel 2 of a vector → o_feature_valid=0 next cycle. o_overflow cleared. The next pushed vector emits starting at channel 0 with o_sof=1.

Source files
------------

// File: rtl/feature_map_serializer.sv
// Buffers whole NUM_CHANNELS-wide feature vectors in a small FIFO and streams them out one channel per cycle
// with sof/eol/eof map markers. Optional macro FEATURE_SERIALIZER_RELU_EN zeroes negative output features.
module feature_map_serializer #(
  parameter int FEATURE_WIDTH = 16,
  parameter int NUM_CHANNELS  = 6,
  parameter int FIFO_DEPTH    = 4,
  parameter int MAP_WIDTH     = 24,
  parameter int MAP_HEIGHT    = 24
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  i_features_valid,
  output logic                                  o_features_ready,
  input  logic [NUM_CHANNELS*FEATURE_WIDTH-1:0] i_features,
  output logic                                  o_feature_valid,
  input  logic                                  i_feature_ready,
  output logic [FEATURE_WIDTH-1:0]              o_feature,
  output logic [$clog2(NUM_CHANNELS)-1:0]       o_channel,
  output logic                                  o_sof,
  output logic                                  o_eol,
  output logic                                  o_eof,
  output logic                                  o_overflow
);

  localparam int PTRW = $clog2(FIFO_DEPTH);
  localparam int CNTW = PTRW + 1;
  localparam int CHW  = $clog2(NUM_CHANNELS);
  localparam int COLW = (MAP_WIDTH > 1) ? $clog2(MAP_WIDTH) : 1;
  localparam int ROWW = (MAP_HEIGHT > 1) ? $clog2(MAP_HEIGHT) : 1;

  localparam logic [CNTW-1:0] DEPTH_C  = CNTW'(FIFO_DEPTH);
  localparam logic [CHW-1:0]  CH_LAST  = CHW'(NUM_CHANNELS - 1);
  localparam logic [COLW-1:0] COL_LAST = COLW'(MAP_WIDTH - 1);
  localparam logic [ROWW-1:0] ROW_LAST = ROWW'(MAP_HEIGHT - 1);

  logic [NUM_CHANNELS-1:0][FEATURE_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [NUM_CHANNELS-1:0][FEATURE_WIDTH-1:0] head;
  logic [FEATURE_WIDTH-1:0] sel;
  logic [PTRW-1:0] wr_ptr, rd_ptr;
  logic [CNTW-1:0] count;
  logic [CHW-1:0]  ch;
  logic [COLW-1:0] col;
  logic [ROWW-1:0] row;
  logic            ovf_q;
  logic            push, fire, pop;

  // Both sides use strict valid/ready: a transfer happens exactly in a cycle where valid && ready;
  // ready comes from the registered count only, so a full FIFO refuses a push even while it pops.
  assign o_features_ready = (count < DEPTH_C) && !rst;
  assign o_feature_valid  = (count != '0) && !rst;
  assign push = i_features_valid && o_features_ready;
  assign fire = o_feature_valid && i_feature_ready;
  assign pop  = fire && (ch == CH_LAST);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= i_features;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ch     <= '0;
      col    <= '0;
      row    <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (fire) ch <= pop ? '0 : ch + 1'b1;
      if (pop) begin
        if (col == COL_LAST) begin
          col <= '0;
          row <= (row == ROW_LAST) ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
      if (i_features_valid && !o_features_ready) ovf_q <= 1'b1;
    end
  end

  assign head = mem[rd_ptr];
  assign sel  = head[ch];

`ifdef FEATURE_SERIALIZER_RELU_EN
  assign o_feature = sel[FEATURE_WIDTH-1] ? '0 : sel;
`else
  assign o_feature = sel;
`endif

  assign o_channel  = ch;
  assign o_sof      = o_feature_valid && (col == '0) && (row == '0) && (ch == '0);
  assign o_eol      = o_feature_valid && (col == COL_LAST) && (ch == CH_LAST);
  assign o_eof      = o_eol && (row == ROW_LAST);
  assign o_overflow = ovf_q && !rst;

endmodule

// File: tb/tb_feature_map_serializer.sv
// Self-checking bench for feature_map_serializer: a cycle table for the basic and stall cases, then
// scoreboard-checked sequences for a full frame, overflow, full-with-pop and mid-vector reset.
module tb_feature_map_serializer;
  localparam int FW = 16, NC = 6, DEPTH = 4, MW = 24, MH = 24, VW = FW * NC;

  logic clk = 1'b0;
  logic rst, i_features_valid, o_features_ready, o_feature_valid, i_feature_ready;
  logic [VW-1:0] i_features;
  logic [FW-1:0] o_feature;
  logic [2:0]    o_channel;
  logic o_sof, o_eol, o_eof, o_overflow;

  always #5 clk = ~clk;

  feature_map_serializer #(
    .FEATURE_WIDTH(FW), .NUM_CHANNELS(NC), .FIFO_DEPTH(DEPTH), .MAP_WIDTH(MW), .MAP_HEIGHT(MH)
  ) dut (
    .clk(clk), .rst(rst),
    .i_features_valid(i_features_valid), .o_features_ready(o_features_ready), .i_features(i_features),
    .o_feature_valid(o_feature_valid), .i_feature_ready(i_feature_ready), .o_feature(o_feature),
    .o_channel(o_channel), .o_sof(o_sof), .o_eol(o_eol), .o_eof(o_eof), .o_overflow(o_overflow)
  );

  typedef struct {
    logic          iv;
    logic [VW-1:0] vec;
    logic          rdy;
    logic          efr;
    logic          ev;
    logic [FW-1:0] efeat;
    logic [2:0]    ech;
    logic          esof;
  } row_t;

  row_t tbl[$];
  logic [FW-1:0] exp_q[$];
  int checks = 0, errors = 0;
  int mw;
  bit mon_en, stall_prev;
  logic [FW-1:0] prev_feat;
  logic [2:0]    prev_ch;
  logic [VW-1:0] v1, v2, vr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [VW-1:0] mk6(input int a, input int b, input int c,
                                        input int d, input int e, input int f);
    return {16'(f), 16'(e), 16'(d), 16'(c), 16'(b), 16'(a)};
  endfunction

  function automatic logic [FW-1:0] ef(input logic [VW-1:0] v, input int c);
    logic [FW-1:0] x;
    x = v[c*FW +: FW];
`ifdef FEATURE_SERIALIZER_RELU_EN
    if (x[FW-1]) x = '0;
`endif
    return x;
  endfunction

  function automatic logic [VW-1:0] rand_vec();
    logic [VW-1:0] v;
    for (int c = 0; c < NC; c++) v[c*FW +: FW] = 16'($urandom_range(0, 65535));
    return v;
  endfunction

  task automatic add(input logic iv, input logic [VW-1:0] vec, input logic rdy, input logic efr,
                     input logic ev, input logic [FW-1:0] efeat, input int ech, input logic esof);
    row_t r;
    r.iv = iv; r.vec = vec; r.rdy = rdy; r.efr = efr;
    r.ev = ev; r.efeat = efeat; r.ech = 3'(ech); r.esof = esof;
    tbl.push_back(r);
  endtask

  // Scoreboard/monitor evaluated on the falling edge, between driver updates.
  task automatic mon_check();
    int chn, pos, col, rw;
    logic [FW-1:0] e;
    if (stall_prev) begin
      chk("stall_valid", 32'(o_feature_valid), 32'(1));
      chk("stall_feature", 32'(o_feature), 32'(prev_feat));
      chk("stall_channel", 32'(o_channel), 32'(prev_ch));
    end
    if (o_feature_valid && i_feature_ready) begin
      chn = mw % NC; pos = mw / NC; col = pos % MW; rw = (pos / MW) % MH;
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_word: got %0h expected none", o_feature);
      end else begin
        e = exp_q.pop_front();
        chk("sb_feature", 32'(o_feature), 32'(e));
      end
      chk("sb_channel", 32'(o_channel), 32'(chn));
      chk("sb_sof", 32'(o_sof), 32'(col == 0 && rw == 0 && chn == 0));
      chk("sb_eol", 32'(o_eol), 32'(col == MW-1 && chn == NC-1));
      chk("sb_eof", 32'(o_eof), 32'(col == MW-1 && chn == NC-1 && rw == MH-1));
      mw++;
    end
    stall_prev = o_feature_valid && !i_feature_ready;
    prev_feat = o_feature;
    prev_ch = o_channel;
  endtask

  task automatic step();
    @(negedge clk);
    if (mon_en) mon_check();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    i_features_valid = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic push_vec(input logic [VW-1:0] v, input bit exp_acc);
    i_features = v;
    i_features_valid = 1'b1;
    chk("features_ready", 32'(o_features_ready), 32'(exp_acc));
    if (exp_acc) for (int c = 0; c < NC; c++) exp_q.push_back(ef(v, c));
    step();
    i_features_valid = 1'b0;
  endtask

  task automatic reset_pulse(input string tag);
    mon_en = 1'b0;
    stall_prev = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk({tag, "_rst_valid"}, 32'(o_feature_valid), 32'(0));
    chk({tag, "_rst_fready"}, 32'(o_features_ready), 32'(0));
    chk({tag, "_rst_ovf"}, 32'(o_overflow), 32'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk({tag, "_post_valid"}, 32'(o_feature_valid), 32'(0));
    chk({tag, "_post_ovf"}, 32'(o_overflow), 32'(0));
    chk({tag, "_post_fready"}, 32'(o_features_ready), 32'(1));
    chk({tag, "_post_channel"}, 32'(o_channel), 32'(0));
    @(posedge clk);
    #1;
    exp_q.delete();
    mw = 0;
  endtask

  initial begin
    rst = 1'b1; i_features_valid = 1'b0; i_features = '0; i_feature_ready = 1'b0;
    mon_en = 1'b0; stall_prev = 1'b0; mw = 0;
    repeat (2) @(posedge clk);
    #1;
    reset_pulse("init");

    // Cycle table: one vector at full rate, then a second vector under stalls.
    v1 = mk6(1, -2, 3, -4, 5, -6);
    v2 = mk6(-100, 200, -300, 400, 32767, -32768);
    add(1, v1, 1, 1, 0, '0, 0, 0);
    for (int c = 0; c < NC; c++) add(0, '0, 1, 1, 1, ef(v1, c), c, c == 0);
    add(0, '0, 1, 1, 0, '0, 0, 0);
    add(1, v2, 0, 1, 0, '0, 0, 0);
    add(0, '0, 0, 1, 1, ef(v2, 0), 0, 0);
    add(0, '0, 1, 1, 1, ef(v2, 0), 0, 0);
    add(0, '0, 0, 1, 1, ef(v2, 1), 1, 0);
    add(0, '0, 0, 1, 1, ef(v2, 1), 1, 0);
    add(0, '0, 1, 1, 1, ef(v2, 1), 1, 0);
    add(0, '0, 1, 1, 1, ef(v2, 2), 2, 0);
    add(0, '0, 0, 1, 1, ef(v2, 3), 3, 0);
    add(0, '0, 1, 1, 1, ef(v2, 3), 3, 0);
    add(0, '0, 1, 1, 1, ef(v2, 4), 4, 0);
    add(0, '0, 1, 1, 1, ef(v2, 5), 5, 0);
    add(0, '0, 1, 1, 0, '0, 0, 0);
    for (int i = 0; i < tbl.size(); i++) begin
      i_features_valid = tbl[i].iv;
      i_features = tbl[i].vec;
      i_feature_ready = tbl[i].rdy;
      @(negedge clk);
      chk($sformatf("tbl%0d_fready", i), 32'(o_features_ready), 32'(tbl[i].efr));
      chk($sformatf("tbl%0d_valid", i), 32'(o_feature_valid), 32'(tbl[i].ev));
      if (tbl[i].ev) begin
        chk($sformatf("tbl%0d_feature", i), 32'(o_feature), 32'(tbl[i].efeat));
        chk($sformatf("tbl%0d_channel", i), 32'(o_channel), 32'(tbl[i].ech));
        chk($sformatf("tbl%0d_sof", i), 32'(o_sof), 32'(tbl[i].esof));
        chk($sformatf("tbl%0d_eol", i), 32'(o_eol), 32'(0));
      end
      @(posedge clk);
      #1;
    end
    i_features_valid = 1'b0;

    // Full frame plus the first vector of the next frame, one vector every NC cycles.
    reset_pulse("frame");
    i_feature_ready = 1'b1;
    mon_en = 1'b1;
    for (int p = 0; p < MW*MH + 1; p++) begin
      push_vec(rand_vec(), 1);
      idle(NC - 1);
    end
    idle(NC);
    chk("frame_words", 32'(mw), 32'(MW*MH*NC + NC));
    chk("frame_q_empty", 32'(exp_q.size()), 32'(0));
    chk("frame_no_ovf", 32'(o_overflow), 32'(0));

    // Backpressure: fill, overflow on a fifth push, then drain in order.
    i_feature_ready = 1'b0;
    for (int k = 0; k < DEPTH; k++) push_vec(rand_vec(), 1);
    chk("full_fready", 32'(o_features_ready), 32'(0));
    push_vec(rand_vec(), 0);
    chk("ovf_set", 32'(o_overflow), 32'(1));
    idle(3);
    chk("ovf_sticky", 32'(o_overflow), 32'(1));
    i_feature_ready = 1'b1;
    idle(DEPTH*NC + 4);
    chk("bp_q_empty", 32'(exp_q.size()), 32'(0));
    chk("ovf_sticky2", 32'(o_overflow), 32'(1));

    // Full FIFO: a push coincident with the last-channel pop is refused, the next one accepted.
    i_feature_ready = 1'b0;
    for (int k = 0; k < DEPTH; k++) push_vec(rand_vec(), 1);
    i_feature_ready = 1'b1;
    idle(NC - 1);
    push_vec(rand_vec(), 0);
    push_vec(rand_vec(), 1);
    chk("refill_full", 32'(o_features_ready), 32'(0));
    idle(DEPTH*NC + 4);
    chk("fp_q_empty", 32'(exp_q.size()), 32'(0));

    // Reset after channel 2 of a vector drops the rest of it.
    vr = rand_vec();
    push_vec(vr, 1);
    idle(3);
    reset_pulse("mid");
    idle(2);
    chk("mid_no_replay", 32'(o_feature_valid), 32'(0));
    mon_en = 1'b1;
    push_vec(v1, 1);
    idle(NC + 2);
    chk("mid_q_empty", 32'(exp_q.size()), 32'(0));
    chk("mid_words", 32'(mw), 32'(NC));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
